// File: rtl/axi4_lite_pkg.sv
// Shared definitions for the AXI4-Lite write path: bus widths, FSM encoding
// and the queued command record.
package axi4_lite_pkg;

   localparam int AXI_ADDR_W = 32;
   localparam int AXI_DATA_W = 32;

   localparam logic [1:0] ST_IDLE  = 2'b01;
   localparam logic [1:0] ST_ISSUE = 2'b10;

   typedef struct packed {
      logic [AXI_ADDR_W-1:0] addr;
      logic [AXI_DATA_W-1:0] data;
   } wr_cmd_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through output; push is ignored when
// full and pop is ignored when empty.
module sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     arst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             do_push;
   logic             do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= din;
   end

   assign dout  = mem[rd_ptr_reg];
   assign full  = (count_reg == (AW+1)'(DEPTH));
   assign empty = (count_reg == '0);
   assign count = count_reg;

endmodule

// File: rtl/axi4_lite_wr_queue.sv
// Queues configuration writes and feeds them one at a time to the AXI4-Lite
// write master, counting completions and flagging stalled writes.
module axi4_lite_wr_queue
   import axi4_lite_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 1024
) (
   input  logic                    clk,
   input  logic                    arst_n,
   input  logic [AXI_ADDR_W-1:0]   cmd_addr,
   input  logic [AXI_DATA_W-1:0]   cmd_data,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   output logic [AXI_ADDR_W-1:0]   wr_addr,
   output logic [AXI_DATA_W-1:0]   wr_data,
   output logic                    wr_valid,
   input  logic                    wr_ready,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    busy,
   output logic [15:0]             done_cnt,
   output logic                    timeout_err,
   input  logic                    err_clr
);

   localparam int TO_W = $clog2(TIMEOUT + 2);
   localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

   logic [1:0]            state_reg;
   logic [AXI_ADDR_W-1:0] wr_addr_reg;
   logic [AXI_DATA_W-1:0] wr_data_reg;
   logic                  wr_valid_reg;
   logic [15:0]           done_cnt_reg;
   logic [TO_W-1:0]       to_cnt_reg;
   logic                  timeout_err_reg;

   wr_cmd_t fifo_dout;
   wr_cmd_t fifo_din;
   logic    fifo_full;
   logic    fifo_empty;
   logic    push;
   logic    load;
   logic    complete;
   logic    to_set;

   assign fifo_din = '{addr: cmd_addr, data: cmd_data};
   assign push     = cmd_valid & cmd_ready;
   assign complete = (state_reg == ST_ISSUE) & wr_ready;
   // Next command loads either from IDLE or on the completing edge, so wr_valid
   // never carries a stale command past wr_ready.
   assign load     = ~fifo_empty & ((state_reg == ST_IDLE) | complete);
   assign to_set   = (TIMEOUT != 0) && (state_reg == ST_ISSUE) && !wr_ready
                     && (to_cnt_reg == TO_W'(TIMEOUT - 1));

   sync_fifo #(
      .WIDTH ($bits(wr_cmd_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk    (clk),
      .arst_n (arst_n),
      .push   (push),
      .pop    (load),
      .din    (fifo_din),
      .dout   (fifo_dout),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .count  (level)
   );

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_reg       <= ST_IDLE;
         wr_addr_reg     <= '0;
         wr_data_reg     <= '0;
         wr_valid_reg    <= 1'b0;
         done_cnt_reg    <= '0;
         to_cnt_reg      <= '0;
         timeout_err_reg <= 1'b0;
      end else begin
         if (load) begin
            wr_addr_reg  <= fifo_dout.addr;
            wr_data_reg  <= fifo_dout.data;
            wr_valid_reg <= 1'b1;
            state_reg    <= ST_ISSUE;
         end else if (complete) begin
            wr_valid_reg <= 1'b0;
            state_reg    <= ST_IDLE;
         end

         if (complete) done_cnt_reg <= done_cnt_reg + 16'd1;

         if (load)
            to_cnt_reg <= '0;
         else if ((state_reg == ST_ISSUE) && (to_cnt_reg != TO_MAX))
            to_cnt_reg <= to_cnt_reg + 1'b1;

         // A new timeout in the same cycle as err_clr keeps the flag set.
         if (to_set)
            timeout_err_reg <= 1'b1;
         else if (err_clr)
            timeout_err_reg <= 1'b0;
      end
   end

   assign cmd_ready   = ~fifo_full;
   assign busy        = wr_valid_reg | ~fifo_empty;
   assign wr_addr     = wr_addr_reg;
   assign wr_data     = wr_data_reg;
   assign wr_valid    = wr_valid_reg;
   assign done_cnt    = done_cnt_reg;
   assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_axi4_lite_wr_queue.sv
// Directed bench for axi4_lite_wr_queue with DEPTH=8, TIMEOUT=16.
module tb_axi4_lite_wr_queue;

   logic        clk = 1'b0;
   logic        arst_n;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_data;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        wr_valid;
   logic        wr_ready;
   logic [3:0]  level;
   logic        busy;
   logic [15:0] done_cnt;
   logic        timeout_err;
   logic        err_clr;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   axi4_lite_wr_queue #(
      .DEPTH   (8),
      .TIMEOUT (16)
   ) dut (
      .clk         (clk),
      .arst_n      (arst_n),
      .cmd_addr    (cmd_addr),
      .cmd_data    (cmd_data),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .level       (level),
      .busy        (busy),
      .done_cnt    (done_cnt),
      .timeout_err (timeout_err),
      .err_clr     (err_clr)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp)
      else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Presents a command for one edge; caller decides whether cmd_valid stays high.
   task automatic push_cmd(input logic [31:0] a, input logic [31:0] d);
      cmd_addr  = a;
      cmd_data  = d;
      cmd_valid = 1'b1;
      step();
      $display("[TB] push addr=%h data=%h level=%0d cmd_ready=%0b", a, d, level, cmd_ready);
   endtask

   task automatic pulse_ready();
      wr_ready = 1'b1;
      step();
      wr_ready = 1'b0;
      $display("[TB] wr_ready pulse: wr_valid=%0b wr_addr=%h done_cnt=%0d", wr_valid, wr_addr, done_cnt);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      arst_n = 1'b0; cmd_addr = '0; cmd_data = '0; cmd_valid = 1'b0;
      wr_ready = 1'b0; err_clr = 1'b0;
      #12;
      check("rst_wr_valid", 32'(wr_valid), 32'd0);
      check("rst_wr_addr", wr_addr, 32'd0);
      check("rst_wr_data", wr_data, 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_done_cnt", 32'(done_cnt), 32'd0);
      check("rst_timeout_err", 32'(timeout_err), 32'd0);
      #5 arst_n = 1'b1;
      step();

      // Single write
      push_cmd(32'h0000_0010, 32'hDEAD_BEEF);
      cmd_valid = 1'b0;
      check("single_not_yet_valid", 32'(wr_valid), 32'd0);
      check("single_level_1", 32'(level), 32'd1);
      step();
      check("single_valid", 32'(wr_valid), 32'd1);
      check("single_addr", wr_addr, 32'h0000_0010);
      check("single_data", wr_data, 32'hDEAD_BEEF);
      check("single_level_0", 32'(level), 32'd0);
      check("single_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 4; i++) step();
      check("single_held_addr", wr_addr, 32'h0000_0010);
      check("single_held_valid", 32'(wr_valid), 32'd1);
      pulse_ready();
      check("single_valid_low", 32'(wr_valid), 32'd0);
      check("single_done_cnt", 32'(done_cnt), 32'd1);
      check("single_busy_low", 32'(busy), 32'd0);

      // Back-to-back
      push_cmd(32'h0000_0100, 32'h1111_1111);
      push_cmd(32'h0000_0104, 32'h2222_2222);
      check("b2b_first_issue", wr_addr, 32'h0000_0100);
      push_cmd(32'h0000_0108, 32'h3333_3333);
      cmd_valid = 1'b0;
      check("b2b_level_2", 32'(level), 32'd2);
      for (int i = 0; i < 3; i++) begin
         step();
         check("b2b_valid_wait1", 32'(wr_valid), 32'd1);
      end
      pulse_ready();
      check("b2b_valid_kept1", 32'(wr_valid), 32'd1);
      check("b2b_addr2", wr_addr, 32'h0000_0104);
      check("b2b_data2", wr_data, 32'h2222_2222);
      check("b2b_level_1", 32'(level), 32'd1);
      check("b2b_done_2", 32'(done_cnt), 32'd2);
      for (int i = 0; i < 4; i++) step();
      pulse_ready();
      check("b2b_valid_kept2", 32'(wr_valid), 32'd1);
      check("b2b_addr3", wr_addr, 32'h0000_0108);
      check("b2b_level_0", 32'(level), 32'd0);
      for (int i = 0; i < 4; i++) step();
      pulse_ready();
      check("b2b_valid_low", 32'(wr_valid), 32'd0);
      check("b2b_done_4", 32'(done_cnt), 32'd4);

      // Full queue: C0 outstanding, C1..C8 queued, C9 stalls
      for (int i = 0; i < 9; i++) push_cmd(32'h0000_0200 + 32'(i * 4), 32'hC000_0000 + 32'(i));
      check("full_level_8", 32'(level), 32'd8);
      check("full_cmd_ready", 32'(cmd_ready), 32'd0);
      check("full_outstanding", wr_addr, 32'h0000_0200);
      cmd_addr = 32'h0000_0224; cmd_data = 32'hC000_0009;
      step();
      step();
      check("full_stall_level", 32'(level), 32'd8);
      check("full_stall_ready", 32'(cmd_ready), 32'd0);
      pulse_ready();
      check("full_pop_level_7", 32'(level), 32'd7);
      check("full_pop_ready", 32'(cmd_ready), 32'd1);
      check("full_pop_addr", wr_addr, 32'h0000_0204);
      check("full_done_5", 32'(done_cnt), 32'd5);
      step();
      cmd_valid = 1'b0;
      check("full_refill_level", 32'(level), 32'd8);
      check("full_refill_ready", 32'(cmd_ready), 32'd0);
      for (int i = 1; i < 10; i++) begin
         check("full_drain_addr", wr_addr, 32'h0000_0200 + 32'(i * 4));
         check("full_drain_data", wr_data, 32'hC000_0000 + 32'(i));
         pulse_ready();
         step();
      end
      check("full_drained_valid", 32'(wr_valid), 32'd0);
      check("full_done_14", 32'(done_cnt), 32'd14);
      check("full_no_timeout", 32'(timeout_err), 32'd0);

      // Timeout after 16 ISSUE cycles
      push_cmd(32'h0000_0300, 32'h5555_AAAA);
      cmd_valid = 1'b0;
      step();
      check("to_issue", 32'(wr_valid), 32'd1);
      for (int i = 0; i < 15; i++) step();
      check("to_not_yet", 32'(timeout_err), 32'd0);
      step();
      check("to_set", 32'(timeout_err), 32'd1);
      step(); step();
      check("to_sticky", 32'(timeout_err), 32'd1);
      check("to_not_aborted", 32'(wr_valid), 32'd1);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("to_cleared", 32'(timeout_err), 32'd0);
      step();
      check("to_stays_clear", 32'(timeout_err), 32'd0);
      pulse_ready();
      check("to_completes", 32'(wr_valid), 32'd0);
      check("to_done_15", 32'(done_cnt), 32'd15);

      // Spurious ready in IDLE
      wr_ready = 1'b1;
      step(); step();
      wr_ready = 1'b0;
      check("spur_done", 32'(done_cnt), 32'd15);
      check("spur_valid", 32'(wr_valid), 32'd0);
      check("spur_level", 32'(level), 32'd0);

      // Reset mid-stream with level=4
      for (int i = 0; i < 5; i++) push_cmd(32'h0000_0400 + 32'(i * 4), 32'hE000_0000 + 32'(i));
      cmd_valid = 1'b0;
      check("mrst_level_4", 32'(level), 32'd4);
      check("mrst_valid_pre", 32'(wr_valid), 32'd1);
      arst_n = 1'b0;
      #1;
      check("mrst_valid", 32'(wr_valid), 32'd0);
      check("mrst_addr", wr_addr, 32'd0);
      check("mrst_data", wr_data, 32'd0);
      check("mrst_level", 32'(level), 32'd0);
      check("mrst_done", 32'(done_cnt), 32'd0);
      check("mrst_busy", 32'(busy), 32'd0);
      check("mrst_cmd_ready", 32'(cmd_ready), 32'd1);
      step(); step();
      #2 arst_n = 1'b1;
      step(); step(); step();
      check("mrst_no_reissue", 32'(wr_valid), 32'd0);
      check("mrst_still_empty", 32'(level), 32'd0);
      push_cmd(32'h0000_0500, 32'h0BAD_F00D);
      cmd_valid = 1'b0;
      step();
      check("mrst_new_valid", 32'(wr_valid), 32'd1);
      check("mrst_new_addr", wr_addr, 32'h0000_0500);
      pulse_ready();
      check("mrst_new_done", 32'(done_cnt), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
